// File: rtl/regfile_sb_if.sv
// Register file bus: writeback write port, two decode read ports, and the
// issue/flush controls that drive the busy scoreboard.
interface regfile_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0] ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;
  logic                  ctrl_issueEnable;
  logic [ADDR_WIDTH-1:0] ctrl_issueReg;
  logic                  ctrl_flush;
  logic                  busy_readRegA;
  logic                  busy_readRegB;
  logic                  busy_any;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    output ctrl_issueEnable, ctrl_issueReg, ctrl_flush,
    input  data_readRegA, data_readRegB,
    input  busy_readRegA, busy_readRegB, busy_any
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    input  ctrl_issueEnable, ctrl_issueReg, ctrl_flush,
    output data_readRegA, data_readRegB,
    output busy_readRegA, busy_readRegB, busy_any
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, optional write-to-read
// bypass and a per-register busy scoreboard for read-after-write hazards.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic         clock,
  input logic         ctrl_reset,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic                  busy_any_q;
  logic                  busy_any_d;
  logic                  write_ok;

  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic                  rd_busy [2];

  always_comb begin
    write_ok = bus.ctrl_writeEnable &&
               !((ZERO_REG != 0) && (bus.ctrl_writeReg == '0));
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_ok) begin
      regs_d[bus.ctrl_writeReg] = bus.data_writeReg;
    end
  end

  // Issue is applied after the write clear so a new producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (bus.ctrl_flush) begin
      busy_d = '0;
    end else begin
      if (bus.ctrl_writeEnable) begin
        busy_d[bus.ctrl_writeReg] = 1'b0;
      end
      if (bus.ctrl_issueEnable) begin
        busy_d[bus.ctrl_issueReg] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
    busy_any_d = |busy_d;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      busy_any_q <= busy_any_d;
    end
  end

  assign rd_addr[0] = bus.ctrl_readRegA;
  assign rd_addr[1] = bus.ctrl_readRegB;

  // A forwarded write also retires the hazard on that register for the reader.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end else if ((BYPASS != 0) && bus.ctrl_writeEnable &&
                   (bus.ctrl_writeReg == rd_addr[p])) begin
        rd_data[p] = bus.data_writeReg;
        rd_busy[p] = 1'b0;
      end else begin
        rd_data[p] = regs_q[rd_addr[p]];
        rd_busy[p] = busy_q[rd_addr[p]];
      end
    end
  end

  assign bus.data_readRegA = rd_data[0];
  assign bus.data_readRegB = rd_data[1];
  assign bus.busy_readRegA = rd_busy[0];
  assign bus.busy_readRegB = rd_busy[1];
  assign bus.busy_any      = busy_any_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default instance and a narrow
// 16-bit/8-entry instance without zero register or bypass, checked against a model.
module tb_regfile_sb;
  logic clock = 1'b0;
  logic ctrl_reset = 1'b0;

  always #5 clock = ~clock;

  regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();
  regfile_sb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus1 ();

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus0.slave)
  );

  regfile_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)) dut_alt (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus1.slave)
  );

  typedef struct {
    bit          we;
    int          wa;
    logic [31:0] wd;
    int          ra;
    int          rb;
    bit          ie;
    int          ia;
    bit          fl;
  } stim_t;

  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    logic        ba;
    logic        bb;
    logic        bany;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];
  int          checks = 0;
  int          errors = 0;

  function automatic int depth_of(int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic bit zero_of(int k);
    return (k == 0);
  endfunction

  function automatic bit bypass_of(int k);
    return (k == 0);
  endfunction

  function automatic stim_t mk(bit we, int wa, logic [31:0] wd, int ra, int rb,
                               bit ie, int ia, bit fl);
    stim_t s;
    s.we = we; s.wa = wa; s.wd = wd; s.ra = ra; s.rb = rb;
    s.ie = ie; s.ia = ia; s.fl = fl;
    return s;
  endfunction

  function automatic logic [31:0] model_data(int k, stim_t s, int addr);
    if (zero_of(k) && addr == 0) return 32'h0;
    if (bypass_of(k) && s.we && s.wa == addr) return s.wd;
    return m_regs[k][addr];
  endfunction

  function automatic logic model_busy(int k, stim_t s, int addr);
    if (zero_of(k) && addr == 0) return 1'b0;
    if (bypass_of(k) && s.we && s.wa == addr) return 1'b0;
    return m_busy[k][addr];
  endfunction

  function automatic exp_t model_out(int k, stim_t s);
    exp_t e;
    e.da   = model_data(k, s, s.ra);
    e.db   = model_data(k, s, s.rb);
    e.ba   = model_busy(k, s, s.ra);
    e.bb   = model_busy(k, s, s.rb);
    e.bany = 1'b0;
    for (int i = 0; i < depth_of(k); i++) begin
      if (m_busy[k][i]) e.bany = 1'b1;
    end
    return e;
  endfunction

  function automatic void model_step(int k, stim_t s, bit rst);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = 32'h0;
        m_busy[k][i] = 1'b0;
      end
      return;
    end
    if (s.we && !(zero_of(k) && s.wa == 0)) m_regs[k][s.wa] = s.wd;
    if (s.fl) begin
      for (int i = 0; i < 32; i++) m_busy[k][i] = 1'b0;
    end else begin
      if (s.we) m_busy[k][s.wa] = 1'b0;
      if (s.ie) m_busy[k][s.ia] = 1'b1;
    end
    if (zero_of(k)) m_busy[k][0] = 1'b0;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive both instances, queue their expected outputs, advance the model.
  task automatic applyStimulus(stim_t s, bit rst, bit push);
    stim_t s1;
    s1 = s;
    s1.wa = s.wa & 7; s1.ra = s.ra & 7; s1.rb = s.rb & 7; s1.ia = s.ia & 7;
    s1.wd = s.wd & 32'h0000_FFFF;
    @(posedge clock);
    #1;
    ctrl_reset = rst;
    bus0.ctrl_writeEnable = s.we;
    bus0.ctrl_writeReg    = s.wa[4:0];
    bus0.data_writeReg    = s.wd;
    bus0.ctrl_readRegA    = s.ra[4:0];
    bus0.ctrl_readRegB    = s.rb[4:0];
    bus0.ctrl_issueEnable = s.ie;
    bus0.ctrl_issueReg    = s.ia[4:0];
    bus0.ctrl_flush       = s.fl;
    bus1.ctrl_writeEnable = s1.we;
    bus1.ctrl_writeReg    = s1.wa[2:0];
    bus1.data_writeReg    = s1.wd[15:0];
    bus1.ctrl_readRegA    = s1.ra[2:0];
    bus1.ctrl_readRegB    = s1.rb[2:0];
    bus1.ctrl_issueEnable = s1.ie;
    bus1.ctrl_issueReg    = s1.ia[2:0];
    bus1.ctrl_flush       = s1.fl;
    if (push) begin
      q0.push_back(model_out(0, s));
      q1.push_back(model_out(1, s1));
    end
    model_step(0, s, rst);
    model_step(1, s1, rst);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checkOutput("dut_dataA", bus0.data_readRegA, e.da);
      checkOutput("dut_dataB", bus0.data_readRegB, e.db);
      checkOutput("dut_busyA", {31'b0, bus0.busy_readRegA}, {31'b0, e.ba});
      checkOutput("dut_busyB", {31'b0, bus0.busy_readRegB}, {31'b0, e.bb});
      checkOutput("dut_busyAny", {31'b0, bus0.busy_any}, {31'b0, e.bany});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checkOutput("alt_dataA", {16'b0, bus1.data_readRegA}, e.da);
      checkOutput("alt_dataB", {16'b0, bus1.data_readRegB}, e.db);
      checkOutput("alt_busyA", {31'b0, bus1.busy_readRegA}, {31'b0, e.ba});
      checkOutput("alt_busyB", {31'b0, bus1.busy_readRegB}, {31'b0, e.bb});
      checkOutput("alt_busyAny", {31'b0, bus1.busy_any}, {31'b0, e.bany});
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    stim_t s;
    bit    rst;
    bus0.ctrl_writeEnable = 1'b0; bus0.ctrl_writeReg = '0; bus0.data_writeReg = '0;
    bus0.ctrl_readRegA = '0; bus0.ctrl_readRegB = '0; bus0.ctrl_issueEnable = 1'b0;
    bus0.ctrl_issueReg = '0; bus0.ctrl_flush = 1'b0;
    bus1.ctrl_writeEnable = 1'b0; bus1.ctrl_writeReg = '0; bus1.data_writeReg = '0;
    bus1.ctrl_readRegA = '0; bus1.ctrl_readRegB = '0; bus1.ctrl_issueEnable = 1'b0;
    bus1.ctrl_issueReg = '0; bus1.ctrl_flush = 1'b0;

    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), 1, 0);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), 1, 1);
    for (int i = 0; i < 32; i++) applyStimulus(mk(0, 0, 0, i, 31 - i, 0, 0, 0), 0, 1);

    $display("[TB] bypass and zero register");
    applyStimulus(mk(1, 5, 32'hDEADBEEF, 5, 5, 0, 0, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 5, 5, 0, 0, 0), 0, 1);
    applyStimulus(mk(1, 0, 32'h12345678, 0, 0, 0, 0, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 0, 5, 0, 0, 0), 0, 1);

    $display("[TB] scoreboard sequence");
    applyStimulus(mk(0, 0, 0, 7, 7, 1, 7, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 1, 7, 0, 0, 0), 0, 1);
    applyStimulus(mk(1, 7, 32'h0000_0777, 1, 7, 1, 7, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 1, 7, 0, 0, 0), 0, 1);
    applyStimulus(mk(1, 7, 32'h0000_0778, 1, 7, 0, 0, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 7, 7, 0, 0, 0), 0, 1);

    $display("[TB] flush sequence");
    applyStimulus(mk(1, 3, 32'h3333_0003, 0, 0, 0, 0, 0), 0, 1);
    applyStimulus(mk(1, 4, 32'h4444_0004, 0, 0, 0, 0, 0), 0, 1);
    applyStimulus(mk(1, 9, 32'h9999_0009, 0, 0, 0, 0, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 3, 4, 1, 3, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 3, 4, 1, 4, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 3, 9, 1, 9, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 9, 10, 1, 10, 1), 0, 1);
    applyStimulus(mk(0, 0, 0, 3, 4, 0, 0, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 9, 10, 0, 0, 0), 0, 1);

    $display("[TB] reset discards a concurrent write");
    applyStimulus(mk(1, 7, 32'h0000_A5A5, 7, 2, 0, 0, 0), 0, 1);
    applyStimulus(mk(0, 0, 0, 7, 2, 0, 0, 0), 0, 1);
    applyStimulus(mk(1, 2, 32'h0000_1111, 7, 2, 1, 2, 0), 1, 1);
    applyStimulus(mk(0, 0, 0, 7, 2, 0, 0, 0), 0, 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      s.we = ($urandom_range(0, 2) != 0);
      s.wa = $urandom_range(0, 31);
      s.wd = $urandom;
      s.ie = ($urandom_range(0, 2) == 0);
      s.ia = $urandom_range(0, 31);
      s.fl = ($urandom_range(0, 15) == 0);
      s.ra = ($urandom_range(0, 3) == 0) ? s.wa : $urandom_range(0, 31);
      s.rb = ($urandom_range(0, 3) == 0) ? s.ia : $urandom_range(0, 31);
      rst  = ($urandom_range(0, 199) == 0);
      applyStimulus(s, rst, 1);
    end

    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    repeat (3) @(posedge clock);
    checkOutput("queue0_drain", q0.size(), 0);
    checkOutput("queue1_drain", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
